// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues imem reads, hands words to decode.
// Ports: clk/reset (async, active-low); alu_out_branch_* redirect in;
//   stall from decode; imem_req/addr/ack/data memory handshake;
//   out_valid/out_instruction/out_program_counter/
//   out_next_program_counter to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_out_branch_enable,
    input  logic [31:0] alu_out_branch_address,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_program_counter,
    output logic [31:0] out_next_program_counter
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic        req_d;
    logic [31:0] addr_d;
    logic        ov_d;
    logic [31:0] oi_d, opc_d, onpc_d;
    logic        skid_valid, skid_valid_d;
    logic [31:0] skid_instr, skid_instr_d;
    logic [31:0] skid_pc, skid_pc_d;

    logic        ack;
    logic        out_free;
    logic [31:0] target;
    logic        issue_en;
    logic [31:0] issue_addr;

    // ack is only meaningful while a request is outstanding
    assign ack      = imem_ack & imem_req;
    assign out_free = ~out_valid | ~stall;
    assign target   = alu_out_branch_address & ~32'h3;

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        req_d        = imem_req;
        addr_d       = imem_addr;
        ov_d         = out_valid;
        oi_d         = out_instruction;
        opc_d        = out_program_counter;
        onpc_d       = out_next_program_counter;
        skid_valid_d = skid_valid;
        skid_instr_d = skid_instr;
        skid_pc_d    = skid_pc;
        issue_en     = 1'b0;
        issue_addr   = pc;

        if (alu_out_branch_enable) begin
            ov_d         = 1'b0;
            skid_valid_d = 1'b0;
            unique case (state)
                IDLE: begin
                    issue_en   = 1'b1;
                    issue_addr = target;
                end
                WAIT, DISCARD: begin
                    if (ack) begin
                        issue_en   = 1'b1;
                        issue_addr = target;
                    end else begin
                        // in-flight word is wrong-path; drop it when it lands
                        state_d = DISCARD;
                        pc_d    = target;
                    end
                end
                default: ;
            endcase
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    ov_d         = 1'b1;
                    oi_d         = skid_instr;
                    opc_d        = skid_pc;
                    onpc_d       = skid_pc + 32'd4;
                    skid_valid_d = 1'b0;
                end else if (ack && state == WAIT) begin
                    ov_d   = 1'b1;
                    oi_d   = imem_data;
                    opc_d  = imem_addr;
                    onpc_d = imem_addr + 32'd4;
                end else begin
                    ov_d = 1'b0;
                end
            end else if (ack && state == WAIT) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_data;
                skid_pc_d    = imem_addr;
            end

            // issue decisions use the skid state after this edge's moves
            unique case (state)
                IDLE: begin
                    issue_en = ~skid_valid_d;
                end
                WAIT: begin
                    if (ack) begin
                        if (!skid_valid_d) begin
                            issue_en = 1'b1;
                        end else begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    issue_en = ack;
                end
                default: ;
            endcase
        end

        if (issue_en) begin
            req_d   = 1'b1;
            addr_d  = issue_addr;
            pc_d    = issue_addr + 32'd4;
            state_d = WAIT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                    <= IDLE;
            pc                       <= RESET_PC;
            imem_req                 <= 1'b0;
            imem_addr                <= RESET_PC;
            out_valid                <= 1'b0;
            out_instruction          <= NOP;
            out_program_counter      <= 32'h0;
            out_next_program_counter <= 32'h0;
            skid_valid               <= 1'b0;
            skid_instr               <= NOP;
            skid_pc                  <= 32'h0;
        end else begin
            state                    <= state_d;
            pc                       <= pc_d;
            imem_req                 <= req_d;
            imem_addr                <= addr_d;
            out_valid                <= ov_d;
            out_instruction          <= oi_d;
            out_program_counter      <= opc_d;
            out_next_program_counter <= onpc_d;
            skid_valid               <= skid_valid_d;
            skid_instr               <= skid_instr_d;
            skid_pc                  <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage.
// Memory model returns addr^A5A5_0000 after a programmable latency.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        br_en;
    logic [31:0] br_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_npc;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int cnt;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .alu_out_branch_enable    (br_en),
        .alu_out_branch_address   (br_addr),
        .stall                    (stall),
        .imem_req                 (imem_req),
        .imem_addr                (imem_addr),
        .imem_ack                 (imem_ack),
        .imem_data                (imem_data),
        .out_valid                (out_valid),
        .out_instruction          (out_instruction),
        .out_program_counter      (out_pc),
        .out_next_program_counter (out_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack  = imem_req && (cnt == lat);
    assign imem_data = imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk or negedge reset) begin
        if (!reset)                    cnt <= 0;
        else if (!imem_req || imem_ack) cnt <= 0;
        else                           cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        br_en   = 1'b0;
        br_addr = 32'h0;
        stall   = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_req",   {31'h0, imem_req},  32'h0);
        chk("rst_addr",  imem_addr,          32'h100);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_instr", out_instruction,    32'h13);
        chk("rst_pc",    out_pc,             32'h0);
        chk("rst_npc",   out_npc,            32'h0);
        tick;
        tick;
        chk("rst_hold_req", {31'h0, imem_req}, 32'h0);
        reset = 1'b1;

        // streaming, zero-wait
        tick;
        chk("e1_req",   {31'h0, imem_req},  32'h1);
        chk("e1_addr",  imem_addr,          32'h100);
        chk("e1_valid", {31'h0, out_valid}, 32'h0);
        tick;
        chk("e2_valid", {31'h0, out_valid}, 32'h1);
        chk("e2_pc",    out_pc,             32'h100);
        chk("e2_npc",   out_npc,            32'h104);
        chk("e2_instr", out_instruction,    32'hA5A5_0100);
        tick;
        chk("e3_pc",  out_pc,  32'h104);
        chk("e3_npc", out_npc, 32'h108);
        tick;
        chk("e4_pc",   out_pc,    32'h108);
        chk("e4_npc",  out_npc,   32'h10C);
        chk("e4_addr", imem_addr, 32'h10C);

        // stall three cycles: 0x10C parks in skid, req drops
        stall = 1'b1;
        tick;
        chk("s1_pc",  out_pc,             32'h108);
        chk("s1_req", {31'h0, imem_req},  32'h0);
        tick;
        chk("s2_pc",  out_pc,             32'h108);
        chk("s2_req", {31'h0, imem_req},  32'h0);
        tick;
        chk("s3_pc",    out_pc,             32'h108);
        chk("s3_valid", {31'h0, out_valid}, 32'h1);
        stall = 1'b0;
        tick;
        chk("s4_pc",    out_pc,             32'h10C);
        chk("s4_instr", out_instruction,    32'hA5A5_010C);
        chk("s4_req",   {31'h0, imem_req},  32'h1);
        chk("s4_addr",  imem_addr,          32'h110);
        tick;
        chk("s5_pc",   out_pc,    32'h110);
        chk("s5_addr", imem_addr, 32'h114);

        // redirect coinciding with ack for 0x114
        br_en   = 1'b1;
        br_addr = 32'h300;
        tick;
        br_en = 1'b0;
        chk("ra_valid", {31'h0, out_valid}, 32'h0);
        chk("ra_addr",  imem_addr,          32'h300);
        chk("ra_req",   {31'h0, imem_req},  32'h1);
        tick;
        chk("ra_pc",    out_pc,             32'h300);
        chk("ra_valid2",{31'h0, out_valid}, 32'h1);
        chk("ra_instr", out_instruction,    32'hA5A5_0300);

        // 3-cycle memory: redirect while 0x304 pending
        lat = 2;
        tick;
        chk("d0_valid", {31'h0, out_valid}, 32'h0);
        br_en   = 1'b1;
        br_addr = 32'h200;
        tick;
        br_en = 1'b0;
        chk("d1_req",   {31'h0, imem_req},  32'h1);
        chk("d1_addr",  imem_addr,          32'h304);
        chk("d1_valid", {31'h0, out_valid}, 32'h0);
        tick;
        chk("d2_addr",  imem_addr,          32'h200);
        chk("d2_valid", {31'h0, out_valid}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick;
            if (out_valid) break;
        end
        chk("d3_valid", {31'h0, out_valid}, 32'h1);
        chk("d3_pc",    out_pc,             32'h200);
        chk("d3_instr", out_instruction,    32'hA5A5_0200);

        // wrap-around target
        lat     = 0;
        br_en   = 1'b1;
        br_addr = 32'hFFFF_FFFF;
        tick;
        br_en = 1'b0;
        chk("w0_addr",  imem_addr,          32'hFFFF_FFFC);
        chk("w0_valid", {31'h0, out_valid}, 32'h0);
        tick;
        chk("w1_pc",   out_pc,    32'hFFFF_FFFC);
        chk("w1_npc",  out_npc,   32'h0);
        chk("w1_addr", imem_addr, 32'h0);
        tick;
        chk("w2_pc",  out_pc,  32'h0);
        chk("w2_npc", out_npc, 32'h4);

        // reset while a request is pending
        lat   = 5;
        stall = 1'b1;
        tick;
        chk("m0_req",   {31'h0, imem_req},  32'h1);
        chk("m0_valid", {31'h0, out_valid}, 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("m1_req",   {31'h0, imem_req},  32'h0);
        chk("m1_addr",  imem_addr,          32'h100);
        chk("m1_valid", {31'h0, out_valid}, 32'h0);
        chk("m1_instr", out_instruction,    32'h13);
        chk("m1_pc",    out_pc,             32'h0);
        chk("m1_npc",   out_npc,            32'h0);
        lat   = 0;
        stall = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        chk("m2_req",  {31'h0, imem_req}, 32'h1);
        chk("m2_addr", imem_addr,         32'h100);
        tick;
        chk("m3_pc",    out_pc,             32'h100);
        chk("m3_valid", {31'h0, out_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
